// File: rtl/flp_arb_pkg.sv
// Shared types and constants for the FlP adder arbiter.
// OVERALL_BITS mirrors the project-wide float width.
package flp_arb_pkg;

    localparam int OVERALL_BITS = 32;
    localparam int MAX_REQ      = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/flp_adder_arbiter_if.sv
// Requester-side bus of the FlP adder arbiter: operand offers and result strobes.
// master = compute engines, slave = arbiter.
interface flp_adder_arbiter_if
    import flp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*OVERALL_BITS-1:0] req_a;
    logic [NUM_REQ*OVERALL_BITS-1:0] req_b;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [OVERALL_BITS-1:0]         rsp_result;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/flp_arb_grant.sv
// One-hot grant from a request vector. FLP_ARB_ROUND_ROBIN_EN selects a rotating
// search starting at i_ptr; otherwise lowest index wins and no pointer port exists.
module flp_arb_grant
    import flp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
`ifdef FLP_ARB_ROUND_ROBIN_EN
    input  logic [id_w(NUM_REQ)-1:0] i_ptr,
`endif
    input  logic [NUM_REQ-1:0]       i_req,
    output logic [NUM_REQ-1:0]       o_grant
);

    logic w_found;
    logic w_hit;

    // Scan requesters in search order; the first active one takes the grant.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FLP_ARB_ROUND_ROBIN_EN
            w_hit = i_req[(int'(i_ptr) + k) % NUM_REQ] & ~w_found;
            o_grant[(int'(i_ptr) + k) % NUM_REQ] = w_hit;
`else
            w_hit = i_req[k] & ~w_found;
            o_grant[k] = w_hit;
`endif
            w_found = w_found | w_hit;
        end
    end

endmodule

// File: rtl/flp_adder_arbiter.sv
// Shares one fixed-latency pipelined FlP adder between NUM_REQ requesters and routes results back.
// Macro FLP_ARB_ROUND_ROBIN_EN: round-robin grant (default build: fixed priority, lowest index wins).
module flp_adder_arbiter
    import flp_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    flp_adder_arbiter_if.slave      bus,
    input  logic                    i_hold,
    output logic                    o_adder_valid,
    output logic [OVERALL_BITS-1:0] o_adder_a,
    output logic [OVERALL_BITS-1:0] o_adder_b,
    input  logic [OVERALL_BITS-1:0] i_adder_result,
    input  logic                    i_adder_done,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int NID_W      = id_w(NUM_REQ);
    localparam int TAG_STAGES = ADDER_LATENCY + 1;
    localparam int MASK_W     = $clog2(ADDER_LATENCY + 2);

    logic [NUM_REQ-1:0]        w_grant;
    logic [NUM_REQ-1:0]        w_ready;
    logic                      w_fire;
    logic [NID_W-1:0]          w_win_id;
    logic [OVERALL_BITS-1:0]   w_win_a;
    logic [OVERALL_BITS-1:0]   w_win_b;
    tag_t                      w_tag_out;
    logic                      w_retire;

    tag_t [TAG_STAGES-1:0]     r_tag;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [OVERALL_BITS-1:0]   r_rsp_result;
    logic [MASK_W-1:0]         r_mask;
    logic                      r_err;

`ifdef FLP_ARB_ROUND_ROBIN_EN
    logic [NID_W-1:0]          r_rr_ptr;
`endif

    flp_arb_grant #(.NUM_REQ(NUM_REQ)) u_grant (
`ifdef FLP_ARB_ROUND_ROBIN_EN
        .i_ptr   (r_rr_ptr),
`endif
        .i_req   (bus.req_valid),
        .o_grant (w_grant)
    );

    // Ready is forced low while reset is asserted so outputs read 0 immediately.
    assign w_ready       = w_grant & {NUM_REQ{~i_hold & rst_n}};
    assign bus.req_ready = w_ready;
    assign w_fire        = |(bus.req_valid & w_ready);

    // Encode the winning index and mux its operands.
    always_comb begin
        w_win_id = '0;
        w_win_a  = '0;
        w_win_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_id = w_win_id | (w_grant[i] ? NID_W'(i) : '0);
            w_win_a  = w_win_a | ({OVERALL_BITS{w_grant[i]}} & bus.req_a[i*OVERALL_BITS +: OVERALL_BITS]);
            w_win_b  = w_win_b | ({OVERALL_BITS{w_grant[i]}} & bus.req_b[i*OVERALL_BITS +: OVERALL_BITS]);
        end
    end

    // Issue registers towards the adder; operands hold when nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_adder_valid <= 1'b0;
            o_adder_a     <= '0;
            o_adder_b     <= '0;
        end else begin
            o_adder_valid <= w_fire;
            if (w_fire) begin
                o_adder_a <= w_win_a;
                o_adder_b <= w_win_b;
            end
        end
    end

`ifdef FLP_ARB_ROUND_ROBIN_EN
    // Rotate the search start past the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= (w_win_id == NID_W'(NUM_REQ - 1)) ? '0 : w_win_id + NID_W'(1);
        end
    end
`endif

    // Requester ID travels beside the adder so its exit lines up with adder done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[TAG_STAGES-2:0], tag_t'{valid: w_fire, id: ID_W'(w_win_id)}};
        end
    end

    assign w_tag_out = r_tag[TAG_STAGES-1];
    assign w_retire  = i_adder_done & w_tag_out.valid;

    // Response strobe to the originator; result holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
        end else begin
            r_rsp_valid <= w_retire ? (NUM_REQ'(1'b1) << w_tag_out.id) : '0;
            if (w_retire) begin
                r_rsp_result <= i_adder_result;
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;

    // The mask window hides done pulses left in the unreset adder after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= MASK_W'(ADDER_LATENCY + 1);
            r_err  <= 1'b0;
        end else begin
            if (r_mask != '0) begin
                r_mask <= r_mask - MASK_W'(1);
            end
            if ((r_mask == '0) && (i_adder_done != w_tag_out.valid)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

    // Busy while any tag stage is occupied.
    always_comb begin
        o_busy = 1'b0;
        for (int s = 0; s < TAG_STAGES; s++) begin
            o_busy = o_busy | r_tag[s].valid;
        end
    end

endmodule

// File: tb/tb_flp_adder_arbiter.sv
// Scoreboard bench for flp_adder_arbiter with a fixed-latency adder stand-in.
// Builds with or without FLP_ARB_ROUND_ROBIN_EN; expected grant orders follow the build.
module tb_flp_adder_arbiter;
    import flp_arb_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 8;
    localparam int OB  = OVERALL_BITS;
`ifdef FLP_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          hold   = 1'b0;
    logic          inject = 1'b0;
    logic          adder_valid;
    logic [OB-1:0] adder_a;
    logic [OB-1:0] adder_b;
    logic [OB-1:0] adder_result;
    logic          adder_done;
    logic          busy;
    logic          err;

    flp_adder_arbiter_if #(.NUM_REQ(NR)) bus ();

    flp_adder_arbiter #(.NUM_REQ(NR), .ADDER_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_hold         (hold),
        .o_adder_valid  (adder_valid),
        .o_adder_a      (adder_a),
        .o_adder_b      (adder_b),
        .i_adder_result (adder_result),
        .i_adder_done   (adder_done),
        .o_busy         (busy),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    // Adder stand-in: LAT register stages, never reset, knows only the bench vectors.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: fadd = 32'h40400000;
            64'h3F800000_3F800000: fadd = 32'h40000000;
            64'h40000000_40000000: fadd = 32'h40800000;
            64'h3F000000_3F000000: fadd = 32'h3F800000;
            default:               fadd = 32'hFFFFFFFF;
        endcase
    endfunction

    logic [LAT-1:0] m_v = '0;
    logic [OB-1:0]  m_r [LAT];

    always @(posedge clk) begin
        m_v    <= {m_v[LAT-2:0], adder_valid};
        m_r[0] <= fadd(adder_a, adder_b);
        for (int s = 1; s < LAT; s++) m_r[s] <= m_r[s-1];
    end

    assign adder_done   = m_v[LAT-1] | inject;
    assign adder_result = m_r[LAT-1];

    // Hand-computed sums: 1+2=3, 1+1=2, 2+2=4, 0.5+0.5=1
    logic [31:0] exp_res [NR] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000};

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        if (bus.rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                m_e = sb_q.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(NR'(1) << m_e.id));
                chk("rsp_result", bus.rsp_result, m_e.res);
                chk("rsp_cycle", 32'(cyc), 32'(m_e.due));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            m_e = sb_q.pop_front();
            chk("rsp_missing", 32'(cyc), 32'(m_e.due));
        end
    end

    task automatic drive_cycle(input logic [NR-1:0] vmask, input logic h, input int exp_id);
        logic [NR-1:0] exp_rdy;
        @(negedge clk);
        bus.req_valid = vmask;
        hold          = h;
        #1;
        exp_rdy = (exp_id < 0) ? '0 : (NR'(1) << exp_id);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (exp_id >= 0) sb_q.push_back('{exp_id, exp_res[exp_id], cyc + LAT + 2});
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle('0, 1'b0, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        hold          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_adder_valid"}, 32'(adder_valid), 32'h0);
        chk({tag, "_adder_a"}, adder_a, 32'h0);
        chk({tag, "_adder_b"}, adder_b, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a = {32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        bus.req_b = {32'h3F000000, 32'h40000000, 32'h3F800000, 32'h40000000};
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single op from requester 0, then operands must hold while idle
        drive_cycle(4'b0001, 1'b0, 0);
        drive_cycle(4'b0000, 1'b0, -1);
        chk("issue_valid", 32'(adder_valid), 32'h1);
        chk("issue_a", adder_a, 32'h3F800000);
        chk("issue_b", adder_b, 32'h40000000);
        drive_cycle(4'b0000, 1'b0, -1);
        chk("idle_valid", 32'(adder_valid), 32'h0);
        chk("idle_a_hold", adder_a, 32'h3F800000);
        idle(12);

        // All four requesting back to back, then shrinking request sets
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(4'b1111, 1'b0, RR ? (i % 4) : 0);
        drive_cycle(4'b1110, 1'b0, 1);
        drive_cycle(4'b1100, 1'b0, 2);
        drive_cycle(4'b1000, 1'b0, 3);
        drive_cycle(4'b1010, 1'b0, 1);
        drive_cycle(4'b0000, 1'b0, -1);
        idle(12);
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_queue", 32'(sb_q.size()), 32'h0);

        // Requesters 0 and 2 contend continuously
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(4'b0101, 1'b0, RR ? ((i % 2) * 2) : 0);
            if (i > 0) chk("contend_busy", 32'(busy), 32'h1);
        end
        idle(12);

        // hold for five cycles mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(4'b1111, 1'b0, RR ? i : 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b1111, 1'b1, -1);
            chk("hold_busy", 32'(busy), 32'h1);
        end
        for (int i = 0; i < 3; i++) drive_cycle(4'b1111, 1'b0, RR ? ((i + 3) % 4) : 0);
        idle(12);
        chk("hold_queue", 32'(sb_q.size()), 32'h0);
        chk("hold_err", 32'(err), 32'h0);

        // Reset with three ops in flight: no responses afterwards, garbage done masked
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(4'b1111, 1'b0, RR ? i : 0);
        idle(2);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        rst_n         = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        sb_q.delete();
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postreset_err", 32'(err), 32'h0);
        chk("postreset_busy", 32'(busy), 32'h0);

        // Spurious done inside and after the mask window
        do_reset();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("masked_err", 32'(err), 32'h0);
        repeat (12) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        chk("spurious_err", 32'(err), 32'h1);
        repeat (5) @(negedge clk);
        chk("sticky_err", 32'(err), 32'h1);
        do_reset();
        #1;
        chk("err_cleared", 32'(err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
